hidden_2_layer_feed_sequencer: RTL
==================================

# hidden_2_layer_feed_sequencer

Sequencer directly upstream of the per-action output-layer nodes. It collects the NUM_INPUT serial activations produced by hidden layer 2, buffers them, and replays them as a contiguous NUM_INPUT+1 beat stream. Each beat pairs one activation, or the bias constant 1.0 on the final beat, with that beat's weight for every output node. Each output node takes one DATA_WIDTH slice of `o_weight` plus the shared `o_data`/`o_valid`, and feeds them into its multiplier-to-33-input-adder chain.

## Interface
Parameters:
- DATA_WIDTH, 32, IEEE-754 single word width; only 32 is supported.
- NUM_INPUT, 32, hidden-2 activations per frame. A frame is NUM_INPUT+1 beats, so 33 by default.
- NUM_OUTPUT, 3, number of output nodes (actions).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  activation beat present.
- i_data  in  DATA_WIDTH  activation value, float32.
- o_ready  out  1  input accepted on an edge where `i_valid & o_ready`.
- i_wr_en  in  1  weight write strobe.
- i_wr_node  in  $clog2(NUM_OUTPUT)  target output node.
- i_wr_addr  in  $clog2(NUM_INPUT+1)  beat index; index NUM_INPUT is the bias weight.
- i_wr_data  in  DATA_WIDTH  weight value.
- o_valid  out  1  stream beat valid.
- o_data  out  DATA_WIDTH  activation for this beat, or 32'h3F800000 on the bias beat.
- o_weight  out  NUM_OUTPUT*DATA_WIDTH  per-node weights; slice n = bits [n*DATA_WIDTH +: DATA_WIDTH].
- o_last  out  1  high on beat NUM_INPUT only.

## Operation
- Weight store: NUM_OUTPUT×(NUM_INPUT+1) registers. The async reset clears every register to 0.
- Weight writes:
  - A write takes effect on the edge where `i_wr_en` is high.
  - Writes with i_wr_addr > NUM_INPUT or i_wr_node ≥ NUM_OUTPUT are ignored.
  - Writes are legal at any time. A beat registered on the same edge as the write carries the old value.
- FSM states:
  - COLLECT: in_cnt runs 0..NUM_INPUT-1. Each accepted input is stored at buf[in_cnt], then in_cnt increments. The edge that accepts input NUM_INPUT-1 (edge E0) moves the FSM to STREAM and resets in_cnt to 0.
  - STREAM: beat_cnt runs 0..NUM_INPUT. Beat k is registered on edge E0+1+k.
    - For k<NUM_INPUT: o_data=buf[k], slice n = W[n][k].
    - For k=NUM_INPUT: o_data=1.0, slice n = W[n][NUM_INPUT], o_last=1.
    - The edge registering beat NUM_INPUT returns the FSM to COLLECT.
- o_ready equals (state==COLLECT), decoded from registered state.
- An i_valid received while o_ready is low is dropped. The upstream block must hold or stall.
- o_valid drops on the edge after the last beat, unless a back-to-back frame starts (see Configuration).
- While o_valid is low, o_data, o_weight and o_last keep their last values; o_last is forced to 0.
- Reset mid-frame discards the partial frame and any stream in progress.
  - Post-reset state: COLLECT with in_cnt=0.
  - Outputs clear to zero.
  - Weights clear to zero. The weights must be reloaded after reset.

## Timing
- Reset values: o_valid=0, o_last=0, o_data=0, o_weight=0, o_ready=1 (COLLECT).
- Latency: beat 0 is registered one edge after the last input is accepted.
- Stream: NUM_INPUT+1 consecutive o_valid cycles with no bubbles; there is no downstream backpressure.
- Non-ping-pong: o_ready is low for NUM_INPUT+1 cycles per frame, from the cycle after E0 through the cycle of beat NUM_INPUT. The minimum frame period is 2·NUM_INPUT+1 cycles.
- Simultaneous i_wr_en and input acceptance are independent and both take effect.

## Configuration
- HIDDEN_2_SEQ_PINGPONG_EN defined:
  - Two activation banks. COLLECT fills the bank that is not streaming.
  - o_ready is low only when one bank is streaming and the other is full.
  - A full bank waiting on a stream starts on the edge after the current beat NUM_INPUT. Result: 2·(NUM_INPUT+1) contiguous o_valid cycles, with o_last high on each frame's final beat.
  - Sustained throughput: one frame per NUM_INPUT+1 cycles.
- Not defined: single bank, behaviour as in Operation.

## Test plan
- Reset, then write W[n][k] = float(100n+k) for all n,k, with bias = float(100n+32). Feed inputs 1.0..32.0 back-to-back. Required:
  - Beat k=0..31 shows o_data=float(k+1) and slice n = float(100n+k).
  - Beat 32 shows o_data=32'h3F800000, o_last=1.
  - o_valid high for exactly 33 cycles.
- Hold i_valid high with o_ready low during STREAM (non-ping-pong). Required: those values are dropped; the next frame contains only inputs accepted after o_ready rises.
- Write W[1][5]=2.0 on the same edge that registers beat 5. Required: beat 5 carries the old value; the next frame carries 2.0.
- Write with i_wr_addr=40 or i_wr_node=3. Required: no weight changes.
- Assert rst_n low after 20 inputs, then release. Required: outputs zero, o_ready=1; the next 32 inputs form a clean frame; weights read as 0.
- With HIDDEN_2_SEQ_PINGPONG_EN, feed 64 inputs continuously. Required: 66 contiguous o_valid cycles, o_last at beats 32 and 65, o_ready never low.

Source files
------------

// File: rtl/hidden_2_layer_feed_sequencer_if.sv
// Bus bundle for hidden_2_layer_feed_sequencer: activation input stream,
// weight-write port, and the replayed beat stream toward the output nodes.
//
// Handshake: an input activation transfers on a rising edge where
// i_valid & o_ready; i_valid while o_ready is low is dropped, not held.
// The outgoing stream has no backpressure: every cycle with o_valid high
// is one beat, and o_last marks the bias beat that closes a frame.
interface hidden_2_layer_feed_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_INPUT  = 32,
    parameter int NUM_OUTPUT = 3
);
    localparam int NODE_W = (NUM_OUTPUT > 1) ? $clog2(NUM_OUTPUT) : 1;
    localparam int ADDR_W = $clog2(NUM_INPUT + 1);

    logic                             i_valid;
    logic [DATA_WIDTH-1:0]            i_data;
    logic                             o_ready;
    logic                             i_wr_en;
    logic [NODE_W-1:0]                i_wr_node;
    logic [ADDR_W-1:0]                i_wr_addr;
    logic [DATA_WIDTH-1:0]            i_wr_data;
    logic                             o_valid;
    logic [DATA_WIDTH-1:0]            o_data;
    logic [NUM_OUTPUT*DATA_WIDTH-1:0] o_weight;
    logic                             o_last;
    logic                             dbg_state;

    modport master (
        output i_valid, i_data, i_wr_en, i_wr_node, i_wr_addr, i_wr_data,
        input  o_ready, o_valid, o_data, o_weight, o_last, dbg_state
    );

    modport slave (
        input  i_valid, i_data, i_wr_en, i_wr_node, i_wr_addr, i_wr_data,
        output o_ready, o_valid, o_data, o_weight, o_last, dbg_state
    );
endinterface

// File: rtl/hidden_2_layer_feed_sequencer.sv
// hidden_2_layer_feed_sequencer
// Collects NUM_INPUT serial hidden-2 activations, then replays them as a
// NUM_INPUT+1 beat stream (last beat = bias constant 1.0) paired with the
// per-node weights held in a NUM_OUTPUT x (NUM_INPUT+1) register store.
//
// Optional feature: define HIDDEN_2_SEQ_PINGPONG_EN for two activation
// banks, so a new frame can be collected while the previous one streams
// and frames replay back to back. Without it a single bank is used and
// input is refused while streaming.
//
// dbg_state exposes the stream FSM (0 = not streaming, 1 = streaming).
module hidden_2_layer_feed_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_INPUT  = 32,
    parameter int NUM_OUTPUT = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    hidden_2_layer_feed_sequencer_if.slave bus
);
    localparam int CNT_W  = $clog2(NUM_INPUT + 1);
    localparam int IDX_W  = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1;
    localparam int NODE_W = (NUM_OUTPUT > 1) ? $clog2(NUM_OUTPUT) : 1;
    localparam int OUT_W  = NUM_OUTPUT * DATA_WIDTH;

    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(NUM_INPUT);
    localparam logic [CNT_W-1:0]      LAST_IN   = CNT_W'(NUM_INPUT - 1);
    localparam logic [NODE_W:0]       NODE_LIM  = (NODE_W + 1)'(NUM_OUTPUT);
    localparam logic [DATA_WIDTH-1:0] BIAS_ONE  = DATA_WIDTH'(32'h3F800000);

    // S_COLLECT: not streaming (single-bank: accepting input).
    // S_STREAM : a frame is being replayed, one beat per edge.
    typedef enum logic {
        S_COLLECT = 1'b0,
        S_STREAM  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic                  o_valid_q, o_valid_d;
    logic                  o_last_q, o_last_d;
    logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
    logic [OUT_W-1:0]      o_weight_q, o_weight_d;
    logic [DATA_WIDTH-1:0] w_q [NUM_OUTPUT][NUM_INPUT+1];
    logic [DATA_WIDTH-1:0] w_d [NUM_OUTPUT][NUM_INPUT+1];
    logic                  wr_ok;
    logic                  ready;
    logic [IDX_W-1:0]      beat_idx;
    logic [OUT_W-1:0]      beat_weight;

`ifdef HIDDEN_2_SEQ_PINGPONG_EN
    logic [DATA_WIDTH-1:0] act_q [2][NUM_INPUT];
    logic [DATA_WIDTH-1:0] act_d [2][NUM_INPUT];
    logic [1:0]            full_q, full_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic                  last_beat;
    logic                  frame_done;
`else
    logic [DATA_WIDTH-1:0] act_q [NUM_INPUT];
    logic [DATA_WIDTH-1:0] act_d [NUM_INPUT];
`endif

    // Weight store next value: legal writes land, out-of-range ones are ignored.
    always_comb begin
        w_d   = w_q;
        wr_ok = bus.i_wr_en && (bus.i_wr_addr <= LAST_BEAT) &&
                ({1'b0, bus.i_wr_node} < NODE_LIM);
        if (wr_ok) begin
            w_d[bus.i_wr_node][bus.i_wr_addr] = bus.i_wr_data;
        end
    end

    // Weight store register; a beat read on a write edge sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q <= '{default: '0};
        end else begin
            w_q <= w_d;
        end
    end

    // Per-node weights for the beat currently addressed by beat_cnt_q.
    always_comb begin
        beat_idx    = beat_cnt_q[IDX_W-1:0];
        beat_weight = '0;
        for (int n = 0; n < NUM_OUTPUT; n++) begin
            beat_weight[n*DATA_WIDTH +: DATA_WIDTH] = w_q[n][beat_cnt_q];
        end
    end

`ifdef HIDDEN_2_SEQ_PINGPONG_EN
    // Two-bank collect/stream control: fill one bank while the other replays.
    always_comb begin
        state_d    = state_q;
        in_cnt_d   = in_cnt_q;
        beat_cnt_d = beat_cnt_q;
        act_d      = act_q;
        full_d     = full_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        o_valid_d  = 1'b0;
        o_last_d   = 1'b0;
        o_data_d   = o_data_q;
        o_weight_d = o_weight_q;

        // The streaming bank frees up on the edge of its bias beat, which
        // reads no activation, so it may start refilling on that same edge.
        last_beat  = (state_q == S_STREAM) && (beat_cnt_q == LAST_BEAT);
        ready      = !full_q[wr_bank_q] || (last_beat && (rd_bank_q == wr_bank_q));
        frame_done = bus.i_valid && ready && (in_cnt_q == LAST_IN);

        case (state_q)
            S_COLLECT: begin
                if (full_q[rd_bank_q] || frame_done) begin
                    state_d    = S_STREAM;
                    beat_cnt_d = '0;
                end
            end
            S_STREAM: begin
                o_valid_d  = 1'b1;
                o_weight_d = beat_weight;
                if (last_beat) begin
                    o_data_d          = BIAS_ONE;
                    o_last_d          = 1'b1;
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                    beat_cnt_d        = '0;
                    if (full_q[~rd_bank_q] || (frame_done && (wr_bank_q != rd_bank_q))) begin
                        state_d = S_STREAM;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end else begin
                    o_data_d   = act_q[rd_bank_q][beat_idx];
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_COLLECT;
        endcase

        if (bus.i_valid && ready) begin
            act_d[wr_bank_q][in_cnt_q[IDX_W-1:0]] = bus.i_data;
            if (in_cnt_q == LAST_IN) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                in_cnt_d          = '0;
            end else begin
                in_cnt_d = in_cnt_q + CNT_W'(1);
            end
        end
    end

    // Bank bookkeeping and activation storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q     <= '{default: '0};
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            act_q     <= act_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
        end
    end
`else
    // Single-bank FSM: collect a full frame, then replay it with input refused.
    always_comb begin
        state_d    = state_q;
        in_cnt_d   = in_cnt_q;
        beat_cnt_d = beat_cnt_q;
        act_d      = act_q;
        o_valid_d  = 1'b0;
        o_last_d   = 1'b0;
        o_data_d   = o_data_q;
        o_weight_d = o_weight_q;
        ready      = (state_q == S_COLLECT);

        case (state_q)
            S_COLLECT: begin
                if (bus.i_valid) begin
                    act_d[in_cnt_q[IDX_W-1:0]] = bus.i_data;
                    if (in_cnt_q == LAST_IN) begin
                        state_d    = S_STREAM;
                        in_cnt_d   = '0;
                        beat_cnt_d = '0;
                    end else begin
                        in_cnt_d = in_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_STREAM: begin
                o_valid_d  = 1'b1;
                o_weight_d = beat_weight;
                if (beat_cnt_q == LAST_BEAT) begin
                    o_data_d   = BIAS_ONE;
                    o_last_d   = 1'b1;
                    state_d    = S_COLLECT;
                    beat_cnt_d = '0;
                end else begin
                    o_data_d   = act_q[beat_idx];
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    // Activation buffer storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q <= '{default: '0};
        end else begin
            act_q <= act_d;
        end
    end
`endif

    // FSM, counters and registered stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_COLLECT;
            in_cnt_q   <= '0;
            beat_cnt_q <= '0;
            o_valid_q  <= 1'b0;
            o_last_q   <= 1'b0;
            o_data_q   <= '0;
            o_weight_q <= '0;
        end else begin
            state_q    <= state_d;
            in_cnt_q   <= in_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            o_valid_q  <= o_valid_d;
            o_last_q   <= o_last_d;
            o_data_q   <= o_data_d;
            o_weight_q <= o_weight_d;
        end
    end

    assign bus.o_ready   = ready;
    assign bus.o_valid   = o_valid_q;
    assign bus.o_last    = o_last_q;
    assign bus.o_data    = o_data_q;
    assign bus.o_weight  = o_weight_q;
    assign bus.dbg_state = state_q;

endmodule
